// File: rtl/dfs_path_counter.sv
// dfs_path_counter
// Counts every distinct path from start_node to end_node in a DAG served by an
// upstream adjacency lookup stage. The search is an iterative DFS over an
// on-chip node stack: a popped node equal to end_node bumps the (saturating)
// path count and is never expanded. Any other popped node is sent out as a
// query, and every successor returned in the reply is pushed.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   start                begin a search (honoured in IDLE only)
//   start_node/end_node  search root and target, captured with start
//   query_*              query request stream to the adjacency stage
//   reply_*              successor beat stream from the adjacency stage
//   busy                 high from accepted start until the done cycle ends
//   done                 one-cycle pulse when the search finishes
//   path_count           result, held stable after done
//   overflow             sticky: a push found the stack full and was dropped
//
// Optional feature macro: DFS_PATH_COUNTER_STATS_EN
//   Adds stat_max_sp (sp high-water mark) and stat_queries (accepted query
//   handshakes). Both clear on rst and on accepted start.
module dfs_path_counter #(
    parameter int MAX_NODES   = 1024,
    parameter int STACK_DEPTH = 4096,
    parameter int COUNT_WIDTH = 48,
    localparam int NODE_WIDTH = $clog2(MAX_NODES),
    localparam int SP_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NODE_WIDTH-1:0]  start_node,
    input  logic [NODE_WIDTH-1:0]  end_node,
    input  logic                   query_ready,
    output logic                   query_valid,
    output logic [NODE_WIDTH-1:0]  query_data,
    input  logic                   reply_valid,
    output logic                   reply_ready,
    input  logic [NODE_WIDTH-1:0]  reply_data,
    input  logic                   reply_last,
    input  logic                   reply_no_edges_found,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] path_count,
`ifdef DFS_PATH_COUNTER_STATS_EN
    output logic [SP_WIDTH-1:0]    stat_max_sp,
    output logic [31:0]            stat_queries,
`endif
    output logic                   overflow
);

    localparam int ADDR_WIDTH = $clog2(STACK_DEPTH);
    localparam logic [SP_WIDTH-1:0]    SP_FULL   = SP_WIDTH'(STACK_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_POP     = 3'd1,
        S_QUERY   = 3'd2,
        S_COLLECT = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SP_WIDTH-1:0]    sp_q, sp_d;
    logic [NODE_WIDTH-1:0]  cur_q, cur_d;
    logic [NODE_WIDTH-1:0]  end_q, end_d;
    logic [COUNT_WIDTH-1:0] path_count_q, path_count_d;
    logic                   overflow_q, overflow_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   query_valid_q, query_valid_d;
    logic                   reply_ready_q, reply_ready_d;
    // first_q marks the first beat of a reply; discard_q swallows the rest of
    // a reply whose first beat said "no edges".
    logic                   first_q, first_d;
    logic                   discard_q, discard_d;
`ifdef DFS_PATH_COUNTER_STATS_EN
    logic [SP_WIDTH-1:0]    max_sp_q, max_sp_d;
    logic [31:0]            queries_q, queries_d;
`endif

    logic [NODE_WIDTH-1:0]  stack_mem [STACK_DEPTH];
    logic                   stack_we_s;
    logic [ADDR_WIDTH-1:0]  stack_waddr_s;
    logic [NODE_WIDTH-1:0]  stack_wdata_s;
    logic [SP_WIDTH-1:0]    sp_m1_s;
    logic [NODE_WIDTH-1:0]  top_s;
    logic                   beat_acc_s;
    logic                   beat_drop_s;

    // Top-of-stack read; only consumed in POP when sp is non-zero.
    assign sp_m1_s     = sp_q - SP_WIDTH'(1);
    assign top_s       = stack_mem[sp_m1_s[ADDR_WIDTH-1:0]];
    assign beat_acc_s  = reply_valid & reply_ready_q;
    assign beat_drop_s = discard_q | (first_q & reply_no_edges_found);

    // Next-state and datapath for the DFS controller.
    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        cur_d         = cur_q;
        end_d         = end_q;
        path_count_d  = path_count_q;
        overflow_d    = overflow_q;
        busy_d        = busy_q;
        first_d       = first_q;
        discard_d     = discard_q;
        stack_we_s    = 1'b0;
        stack_waddr_s = '0;
        stack_wdata_s = '0;
`ifdef DFS_PATH_COUNTER_STATS_EN
        max_sp_d      = max_sp_q;
        queries_d     = queries_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stack_we_s    = 1'b1;
                    stack_waddr_s = '0;
                    stack_wdata_s = start_node;
                    sp_d          = SP_WIDTH'(1);
                    end_d         = end_node;
                    path_count_d  = '0;
                    overflow_d    = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = S_POP;
`ifdef DFS_PATH_COUNTER_STATS_EN
                    max_sp_d      = '0;
                    queries_d     = 32'd0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_POP: begin
                if (sp_q == {SP_WIDTH{1'b0}}) begin
                    state_d = S_FINISH;
                end else begin
                    cur_d = top_s;
                    sp_d  = sp_m1_s;
                    if (top_s == end_q) begin
                        if (path_count_q != COUNT_MAX) begin
                            path_count_d = path_count_q + COUNT_WIDTH'(1);
                        end else begin
                            path_count_d = path_count_q;
                        end
                        state_d = S_POP;
                    end else begin
                        state_d = S_QUERY;
                    end
                end
            end
            S_QUERY: begin
                if (query_valid_q && query_ready) begin
                    first_d   = 1'b1;
                    discard_d = 1'b0;
                    state_d   = S_COLLECT;
`ifdef DFS_PATH_COUNTER_STATS_EN
                    queries_d = queries_q + 32'd1;
`endif
                end else begin
                    state_d = S_QUERY;
                end
            end
            S_COLLECT: begin
                if (beat_acc_s) begin
                    first_d = 1'b0;
                    if (beat_drop_s) begin
                        discard_d = 1'b1;
                    end else if (sp_q == SP_FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        stack_we_s    = 1'b1;
                        stack_waddr_s = sp_q[ADDR_WIDTH-1:0];
                        stack_wdata_s = reply_data;
                        sp_d          = sp_q + SP_WIDTH'(1);
                    end
                    if (reply_last) begin
                        state_d = S_POP;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DFS_PATH_COUNTER_STATS_EN
        if (sp_d > max_sp_d) begin
            max_sp_d = sp_d;
        end else begin
            max_sp_d = max_sp_d;
        end
`endif
        // Handshake outputs are registered, so they are decoded from the
        // state being entered rather than the current one.
        query_valid_d = (state_d == S_QUERY);
        reply_ready_d = (state_d == S_IDLE) || (state_d == S_COLLECT);
        done_d        = (state_d == S_FINISH);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sp_q          <= '0;
            cur_q         <= '0;
            end_q         <= '0;
            path_count_q  <= '0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            query_valid_q <= 1'b0;
            reply_ready_q <= 1'b0;
            first_q       <= 1'b0;
            discard_q     <= 1'b0;
`ifdef DFS_PATH_COUNTER_STATS_EN
            max_sp_q      <= '0;
            queries_q     <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            cur_q         <= cur_d;
            end_q         <= end_d;
            path_count_q  <= path_count_d;
            overflow_q    <= overflow_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            query_valid_q <= query_valid_d;
            reply_ready_q <= reply_ready_d;
            first_q       <= first_d;
            discard_q     <= discard_d;
`ifdef DFS_PATH_COUNTER_STATS_EN
            max_sp_q      <= max_sp_d;
            queries_q     <= queries_d;
`endif
        end
    end

    // Node stack storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!rst && stack_we_s) begin
            stack_mem[stack_waddr_s] <= stack_wdata_s;
        end
    end

    assign query_valid = query_valid_q;
    assign query_data  = cur_q;
    assign reply_ready = reply_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign path_count  = path_count_q;
    assign overflow    = overflow_q;
`ifdef DFS_PATH_COUNTER_STATS_EN
    assign stat_max_sp  = max_sp_q;
    assign stat_queries = queries_q;
`endif

endmodule

// File: tb/tb_dfs_path_counter.sv
// Testbench for dfs_path_counter. The bench plays the adjacency lookup stage
// from a small graph table and keeps a scoreboard of expected search results.
// A small stack (4) and a 2-bit counter put overflow and saturation in reach.
module tb_dfs_path_counter;
    localparam int MAXN   = 1024;
    localparam int SD     = 4;
    localparam int CW     = 2;
    localparam int NW     = 10;
    localparam int SPW    = 3;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rst, start, query_ready, reply_valid, reply_last, reply_ne;
    logic [NW-1:0] start_node, end_node, reply_data;
    logic          query_valid, reply_ready, busy, done, overflow;
    logic [NW-1:0] query_data;
    logic [CW-1:0] path_count;
`ifdef DFS_PATH_COUNTER_STATS_EN
    logic [SPW-1:0] stat_max_sp;
    logic [31:0]    stat_queries;
`endif

    always #5 clk = ~clk;

    dfs_path_counter #(.MAX_NODES(MAXN), .STACK_DEPTH(SD), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_node(start_node),
        .end_node(end_node), .query_ready(query_ready), .query_valid(query_valid),
        .query_data(query_data), .reply_valid(reply_valid), .reply_ready(reply_ready),
        .reply_data(reply_data), .reply_last(reply_last),
        .reply_no_edges_found(reply_ne), .busy(busy), .done(done),
        .path_count(path_count),
`ifdef DFS_PATH_COUNTER_STATS_EN
        .stat_max_sp(stat_max_sp), .stat_queries(stat_queries),
`endif
        .overflow(overflow));

    typedef struct { logic [NW-1:0] data; logic last; logic ne; } beat_t;
    typedef struct { int count; int ovf; int queries; } exp_t;

    beat_t         bq[$];
    exp_t          sb[$];
    int            adj_cnt  [MAXN];
    int            ne_beats [MAXN];
    logic [NW-1:0] garb     [MAXN];
    logic [NW-1:0] adj_tab  [MAXN][8];
    int            n_assert = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_graph();
        for (int i = 0; i < MAXN; i++) begin
            adj_cnt[i]  = 0;
            ne_beats[i] = 1;
            garb[i]     = '0;
        end
    endtask

    task automatic add_edge(input int u, input int v);
        adj_tab[u][adj_cnt[u]] = NW'(v);
        adj_cnt[u]++;
    endtask

    // a=1 b=2 c=3 d=4 e=5: a->{b,c}, b->d, c->d, d->e
    task automatic load_ae();
        clear_graph();
        add_edge(1, 2); add_edge(1, 3); add_edge(2, 4); add_edge(3, 4); add_edge(4, 5);
    endtask

    task automatic push_exp(input int c, input int o, input int q);
        exp_t e;
        e.count = c; e.ovf = o; e.queries = q;
        sb.push_back(e);
    endtask

    // Queue the reply beats the adjacency stage returns for node u.
    task automatic enqueue_reply(input logic [NW-1:0] u);
        beat_t b;
        if (adj_cnt[u] == 0) begin
            for (int j = 0; j < ne_beats[u]; j++) begin
                b.data = garb[u] + NW'(j);
                b.last = (j == ne_beats[u] - 1);
                b.ne   = (j == 0);
                bq.push_back(b);
            end
        end else begin
            for (int j = 0; j < adj_cnt[u]; j++) begin
                b.data = adj_tab[u][j];
                b.last = (j == adj_cnt[u] - 1);
                b.ne   = 1'b0;
                bq.push_back(b);
            end
        end
    endtask

    // One search. stall: cycles query_ready stays low per query; gaps: random
    // reply_valid bubbles; poke: start pulse mid-search; abort: rst during the
    // first reply; lat: expected start->done cycles (0 = not checked).
    task automatic run(input string tag, input int s, input int e, input int stall,
                       input bit gaps, input bit poke, input bit abort, input int lat);
        int            cyc, qn, stall_left, beats_acc, k;
        logic          last_rv, last_rr, last_qv, last_qr, held, qd_bad, aborted;
        logic [NW-1:0] held_qd;
        exp_t          ex;
        @(negedge clk);
        start = 1'b1; start_node = NW'(s); end_node = NW'(e);
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy after start"}, 64'(busy), 64'd1);
        cyc = 1; qn = 0; stall_left = stall; beats_acc = 0; bq.delete();
        last_rv = 1'b0; last_rr = 1'b0; last_qv = 1'b0; last_qr = 1'b0;
        held = 1'b0; qd_bad = 1'b0; aborted = 1'b0; held_qd = '0;
        while (done !== 1'b1 && cyc < BUDGET) begin
            if (last_rv && last_rr) begin
                void'(bq.pop_front());
                beats_acc++;
            end
            if (last_qv && last_qr) begin
                qn++;
                enqueue_reply(held_qd);
                held = 1'b0; stall_left = stall; beats_acc = 0;
            end
            if (abort && qn >= 1 && beats_acc > 0 && bq.size() > 0) begin
                aborted = 1'b1;
                break;
            end
            if (query_valid === 1'b1) begin
                if (held && query_data !== held_qd) qd_bad = 1'b1;
                held = 1'b1; held_qd = query_data;
            end
            query_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            if (query_valid === 1'b1 && stall_left > 0) stall_left--;
            last_qv = query_valid; last_qr = query_ready;
            if (bq.size() > 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
                reply_valid = 1'b1; reply_data = bq[0].data;
                reply_last = bq[0].last; reply_ne = bq[0].ne;
            end else begin
                reply_valid = 1'b0; reply_data = NW'($urandom_range(0, MAXN - 1));
                reply_last = 1'b0; reply_ne = 1'b0;
            end
            last_rv = reply_valid; last_rr = reply_ready;
            start = poke && (cyc == 6);
            if (start) begin
                start_node = NW'(7); end_node = NW'(7);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; reply_valid = 1'b0; query_ready = 1'b0;
        if (aborted) begin
            rst = 1'b1;
            @(negedge clk);
            check({tag, " busy in rst"}, 64'(busy), 64'd0);
            check({tag, " count in rst"}, 64'(path_count), 64'd0);
            check({tag, " ready in rst"}, 64'(reply_ready), 64'd0);
            rst = 1'b0; last_rv = 1'b0; k = 0;
            while (k < 50) begin
                if (last_rv && last_rr) void'(bq.pop_front());
                if (bq.size() == 0) break;
                reply_valid = 1'b1; reply_data = bq[0].data;
                reply_last = bq[0].last; reply_ne = bq[0].ne;
                last_rv = reply_valid; last_rr = reply_ready;
                @(negedge clk);
                k++;
            end
            reply_valid = 1'b0;
            check({tag, " drained"}, 64'(bq.size()), 64'd0);
            check({tag, " idle after drain"}, 64'(busy), 64'd0);
        end else if (done !== 1'b1) begin
            check({tag, " timeout"}, 64'd0, 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            ex = sb.pop_front();
            check({tag, " path_count"}, 64'(path_count), 64'(ex.count));
            check({tag, " overflow"}, 64'(overflow), 64'(ex.ovf));
            check({tag, " queries"}, 64'(qn), 64'(ex.queries));
            if (ex.queries > 0) check({tag, " query_data stable"}, 64'(qd_bad), 64'd0);
            if (lat > 0) check({tag, " latency"}, 64'(cyc), 64'(lat));
            @(negedge clk);
            check({tag, " done one pulse"}, 64'(done), 64'd0);
            check({tag, " busy cleared"}, 64'(busy), 64'd0);
            check({tag, " count held"}, 64'(path_count), 64'(ex.count));
        end
    endtask

    // Directed sequence of searches.
    initial begin
        rst = 1'b1; start = 1'b0; start_node = '0; end_node = '0;
        query_ready = 1'b0; reply_valid = 1'b0; reply_data = '0;
        reply_last = 1'b0; reply_ne = 1'b0;
        clear_graph();
        repeat (3) @(negedge clk);
        check("rst query_valid", 64'(query_valid), 64'd0);
        check("rst reply_ready", 64'(reply_ready), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst path_count", 64'(path_count), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle reply_ready", 64'(reply_ready), 64'd1);

        load_ae();
        push_exp(2, 0, 5);
        run("ae", 1, 5, 0, 1'b0, 1'b0, 1'b0, 0);

        clear_graph();
        push_exp(1, 0, 0);
        run("self", 7, 7, 0, 1'b0, 1'b0, 1'b0, 3);

        // Garbage beats include the target id: pushing any of them would count.
        clear_graph();
        ne_beats[20] = 3; garb[20] = NW'(21);
        push_exp(0, 0, 1);
        run("noedge", 20, 21, 0, 1'b0, 1'b0, 1'b0, 0);

        // 6 successors into a 4-deep stack: 14 and 15 are dropped.
        clear_graph();
        for (int v = 10; v < 16; v++) add_edge(30, v);
        garb[10] = NW'(11); garb[12] = NW'(11); garb[13] = NW'(11);
        push_exp(1, 1, 4);
        run("ovf", 30, 11, 0, 1'b0, 1'b0, 1'b0, 0);

        load_ae();
        push_exp(2, 0, 5);
        run("stall", 1, 5, 10, 1'b1, 1'b1, 1'b0, 0);

        // Four hits fill the stack exactly (no overflow); 2-bit count saturates.
        clear_graph();
        for (int j = 0; j < 4; j++) add_edge(40, 5);
        push_exp(3, 0, 1);
        run("sat", 40, 5, 0, 1'b0, 1'b0, 1'b0, 0);

        load_ae();
        run("abort", 1, 5, 0, 1'b0, 1'b0, 1'b1, 0);
        push_exp(2, 0, 5);
        run("after_rst", 1, 5, 0, 1'b0, 1'b0, 1'b0, 0);

        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
